// File: rtl/zero_scan_pkg.sv
// Shared definitions for the zero scan engine.
// Holds the FSM state encoding and the scan-mode encoding used by the top
// level and by the testbench.
package zero_scan_pkg;

  typedef logic [1:0] zs_state_t;

  // FSM states
  localparam zs_state_t ST_IDLE = 2'd0;
  localparam zs_state_t ST_SCAN = 2'd1;
  localparam zs_state_t ST_DONE = 2'd2;

  // Scan mode: which end of the word the zero count starts from
  localparam logic ZS_TRAILING = 1'b0;
  localparam logic ZS_LEADING  = 1'b1;

endpackage

// File: rtl/zero_count_chunk.sv
// Combinational trailing-zero counter for one chunk.
// Ports:
//   i_chunk : CHUNK_WIDTH-bit slice to examine
//   o_count : number of zeros below the lowest set bit (CHUNK_WIDTH if none)
//   o_zero  : chunk is all zeros
module zero_count_chunk #(
  parameter int CHUNK_WIDTH = 8
) (
  input  logic [CHUNK_WIDTH-1:0]      i_chunk,
  output logic [$clog2(CHUNK_WIDTH):0] o_count,
  output logic                         o_zero
);

  localparam int CNT_W = $clog2(CHUNK_WIDTH) + 1;

  // Priority search from the top down so the lowest set bit is the last to win
  always_comb begin
    o_count = CNT_W'(CHUNK_WIDTH);
    for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
      o_count = i_chunk[i] ? CNT_W'(i) : o_count;
    end
    o_zero = (i_chunk == {CHUNK_WIDTH{1'b0}});
  end

endmodule

// File: rtl/zero_scan_engine.sv
// Multi-cycle leading/trailing zero counter.
// A captured word is scanned one chunk per cycle starting at the LSB
// (trailing mode) or the MSB (leading mode); the scan stops at the first
// nonzero chunk.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   din, mode            : word to scan and scan direction (0 trailing, 1 leading)
//   in_valid, in_ready   : input handshake (ready only when idle)
//   dout, dout_zero      : zero count and all-zero flag
//   out_valid, out_ready : output handshake
module zero_scan_engine
  import zero_scan_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [DATA_WIDTH-1:0]       din,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [$clog2(DATA_WIDTH):0] dout,
  output logic                        dout_zero,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int K_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int OUT_W      = $clog2(DATA_WIDTH) + 1;
  localparam int CNT_W      = $clog2(CHUNK_WIDTH) + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_CHUNKS - 1);

  if ((DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_chunk_width
    $error("zero_scan_engine: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
  end

  zs_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_mode;
  logic [K_W-1:0]        r_k;
  logic [OUT_W-1:0]      r_dout;
  logic                  r_dout_zero;
  logic                  r_out_valid;

  int                     w_base;
  logic [CHUNK_WIDTH-1:0] w_chunk_sel;
  logic [CHUNK_WIDTH-1:0] w_chunk_cnt;
  logic [CNT_W-1:0]       w_local;
  logic                   w_chunk_zero;
  logic [OUT_W-1:0]       w_hit_count;

  // Select chunk k from the scan end; leading mode reverses it so the single
  // trailing counter yields the leading-zero count
  always_comb begin
    w_base = (r_mode == ZS_LEADING) ? (NUM_CHUNKS - 1 - int'(r_k)) * CHUNK_WIDTH
                                    : int'(r_k) * CHUNK_WIDTH;
    w_chunk_sel = r_data[w_base +: CHUNK_WIDTH];
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      w_chunk_cnt[i] = (r_mode == ZS_LEADING) ? w_chunk_sel[CHUNK_WIDTH-1-i] : w_chunk_sel[i];
    end
  end

  zero_count_chunk #(
    .CHUNK_WIDTH(CHUNK_WIDTH)
  ) u_count (
    .i_chunk (w_chunk_cnt),
    .o_count (w_local),
    .o_zero  (w_chunk_zero)
  );

  // Full count = zeros in the chunks already skipped plus the local count
  always_comb begin
    w_hit_count = OUT_W'(int'(r_k) * CHUNK_WIDTH) + OUT_W'(w_local);
  end

  // Scan FSM: capture, chunk-by-chunk scan, then hold the result until taken.
  // DONE spends one cycle before raising out_valid, giving the hit-in-chunk-k
  // result at T+2+k after acceptance at T.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_data      <= {DATA_WIDTH{1'b0}};
      r_mode      <= ZS_TRAILING;
      r_k         <= {K_W{1'b0}};
      r_dout      <= {OUT_W{1'b0}};
      r_dout_zero <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_data  <= din;
            r_mode  <= mode;
            r_k     <= {K_W{1'b0}};
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!w_chunk_zero) begin
            r_dout      <= w_hit_count;
            r_dout_zero <= 1'b0;
            r_state     <= ST_DONE;
          end else if (r_k == K_LAST) begin
            r_dout      <= OUT_W'(DATA_WIDTH);
            r_dout_zero <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_k <= r_k + K_W'(1);
          end
        end
        ST_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_k         <= {K_W{1'b0}};
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_k         <= {K_W{1'b0}};
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Input acceptance depends only on the current state
  always_comb begin
    in_ready = (r_state == ST_IDLE);
  end

  assign dout      = r_dout;
  assign dout_zero = r_dout_zero;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_zero_scan_engine.sv
// Directed testbench for zero_scan_engine (DATA_WIDTH=32, CHUNK_WIDTH=8).
module tb_zero_scan_engine;
  import zero_scan_pkg::*;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] din = 32'h0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    dout;
  logic          dout_zero;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  zero_scan_engine #(
    .DATA_WIDTH (DW),
    .CHUNK_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .din      (din),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout     (dout),
    .dout_zero(dout_zero),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a word for one accepting edge, then scramble din/mode
  task automatic start_word(input string tag, input logic [31:0] d, input logic m);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    din = d;
    mode = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din = ~d;
    mode = ~m;
  endtask

  // Count edges after acceptance until out_valid (bounded)
  task automatic wait_out(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_word(input string tag, input logic [31:0] d, input logic m,
                          input int exp_dout, input logic exp_zero, input int exp_lat);
    start_word(tag, d, m);
    wait_out(tag, exp_lat);
    check({tag, "_dout"}, {26'd0, dout}, exp_dout);
    check({tag, "_zero"}, {31'd0, dout_zero}, {31'd0, exp_zero});
    release_out(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while resetn is low
    @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dout", {26'd0, dout}, 32'd0);
    check("rst_dout_zero", {31'd0, dout_zero}, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("rst_in_ready_after", {31'd0, in_ready}, 32'd1);

    // Hits in various chunks, both directions
    run_word("lsb_tz", 32'h0000_0001, ZS_TRAILING, 0, 1'b0, 2);
    run_word("msb_tz", 32'h8000_0000, ZS_TRAILING, 31, 1'b0, 5);
    run_word("msb_lz", 32'h8000_0000, ZS_LEADING, 0, 1'b0, 2);
    run_word("zero_tz", 32'h0000_0000, ZS_TRAILING, 32, 1'b1, 5);
    run_word("zero_lz", 32'h0000_0000, ZS_LEADING, 32, 1'b1, 5);
    run_word("b16_lz", 32'h0001_0000, ZS_LEADING, 15, 1'b0, 3);
    run_word("b16_tz", 32'h0001_0000, ZS_TRAILING, 16, 1'b0, 4);
    run_word("f000_tz", 32'h0000_F000, ZS_TRAILING, 12, 1'b0, 3);
    run_word("f000_lz", 32'h0000_F000, ZS_LEADING, 16, 1'b0, 4);
    run_word("b8_lz", 32'h0000_0100, ZS_LEADING, 23, 1'b0, 4);

    // Output stall with a competing input request
    start_word("stall", 32'h0000_0001, ZS_TRAILING);
    wait_out("stall", 2);
    in_valid = 1'b1;
    din = 32'hFFFF_0000;
    mode = ZS_LEADING;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("stall_dout", {26'd0, dout}, 32'd0);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_out("stall");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_no_capture", {31'd0, out_valid}, 32'd0);
    end

    // Reset during SCAN discards the word
    start_word("rst_scan", 32'h8000_0000, ZS_TRAILING);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #2;
    check("rst_scan_valid", {31'd0, out_valid}, 32'd0);
    check("rst_scan_dout", {26'd0, dout}, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("rst_scan_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("rst_scan_no_out", {31'd0, out_valid}, 32'd0);
    end
    run_word("post_rst", 32'h0001_0000, ZS_LEADING, 15, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
